// File: rtl/ball_mover.sv
// Maze ball position controller: moves the ball one pixel per axis every SPEED_DIV
// frames, honouring wall contacts and screen bounds, and latches arrival in the goal box.
module ball_mover #(
    parameter int X_START   = 30,
    parameter int Y_START   = 30,
    parameter int BALL_W    = 10,
    parameter int SPEED_DIV = 2,
    parameter int TICK_LINE = 481,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479,
    parameter int GOAL_X0   = 560,
    parameter int GOAL_X1   = 600,
    parameter int GOAL_Y0   = 400,
    parameter int GOAL_Y1   = 440
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcounter,
    input  logic [10:0] vcounter,
    input  logic        move_right,
    input  logic        move_left,
    input  logic        move_up,
    input  logic        move_down,
    input  logic        stop_right,
    input  logic        stop_left,
    input  logic        stop_up,
    input  logic        stop_down,
    input  logic        restart,
    output logic [10:0] x_ball,
    output logic [10:0] y_ball,
    output logic [4:0]  ball_width,
    output logic        ball_enable,
    output logic        goal_reached,
    output logic        frame_tick
);
    localparam logic [10:0] L_X_START   = 11'(X_START);
    localparam logic [10:0] L_Y_START   = 11'(Y_START);
    localparam logic [10:0] L_BW        = 11'(BALL_W);
    localparam logic [4:0]  L_BW5       = 5'(BALL_W);
    localparam logic [3:0]  L_DIV_LAST  = 4'(SPEED_DIV - 1);
    localparam logic [10:0] L_TICK_LINE = 11'(TICK_LINE);
    localparam logic [10:0] L_X_MIN     = 11'(X_MIN);
    localparam logic [10:0] L_X_MAX     = 11'(X_MAX);
    localparam logic [10:0] L_Y_MIN     = 11'(Y_MIN);
    localparam logic [10:0] L_Y_MAX     = 11'(Y_MAX);
    localparam logic [10:0] L_GOAL_X0   = 11'(GOAL_X0);
    localparam logic [10:0] L_GOAL_X1   = 11'(GOAL_X1);
    localparam logic [10:0] L_GOAL_Y0   = 11'(GOAL_Y0);
    localparam logic [10:0] L_GOAL_Y1   = 11'(GOAL_Y1);

    typedef enum logic {
        S_PLAY = 1'b0,
        S_GOAL = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic [10:0] w_x_next;
    logic [10:0] w_y_next;
    logic [3:0]  r_div;
    logic [3:0]  w_div_next;
    logic        r_tick_d;
    logic        r_frame_tick;
    logic        r_goal;
    logic        w_tick_cond;
    logic [10:0] w_x_far;
    logic [10:0] w_y_far;
    logic        w_in_goal;
    logic        w_can_right;
    logic        w_can_left;
    logic        w_can_down;
    logic        w_can_up;

    assign w_tick_cond = (hcounter == 11'd0) && (vcounter == L_TICK_LINE);
    assign w_x_far     = r_x + L_BW - 11'd1;
    assign w_y_far     = r_y + L_BW - 11'd1;
    assign w_in_goal   = (r_x >= L_GOAL_X0) && (w_x_far <= L_GOAL_X1) &&
                         (r_y >= L_GOAL_Y0) && (w_y_far <= L_GOAL_Y1);

    // Walls are sampled only on the step cycle, when the position has been stable a frame.
    assign w_can_right = move_right & ~move_left & ~stop_right & (w_x_far < L_X_MAX);
    assign w_can_left  = move_left & ~move_right & ~stop_left & (r_x > L_X_MIN);
    assign w_can_down  = move_down & ~move_up & ~stop_down & (w_y_far < L_Y_MAX);
    assign w_can_up    = move_up & ~move_down & ~stop_up & (r_y > L_Y_MIN);

    // Next-state, frame divider and one-pixel step logic; restart overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_div_next   = r_div;
        if (restart) begin
            w_state_next = S_PLAY;
            w_x_next     = L_X_START;
            w_y_next     = L_Y_START;
            w_div_next   = 4'd0;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (r_frame_tick && (r_div == L_DIV_LAST)) begin
                        w_div_next = 4'd0;
                        if (w_can_right) begin
                            w_x_next = r_x + 11'd1;
                        end else if (w_can_left) begin
                            w_x_next = r_x - 11'd1;
                        end else begin
                            w_x_next = r_x;
                        end
                        if (w_can_down) begin
                            w_y_next = r_y + 11'd1;
                        end else if (w_can_up) begin
                            w_y_next = r_y - 11'd1;
                        end else begin
                            w_y_next = r_y;
                        end
                    end else if (r_frame_tick) begin
                        w_div_next = r_div + 4'd1;
                    end else begin
                        w_div_next = r_div;
                    end
                    if (w_in_goal) begin
                        w_state_next = S_GOAL;
                    end else begin
                        w_state_next = S_PLAY;
                    end
                end
                S_GOAL: begin
                    w_state_next = S_GOAL;
                end
                default: begin
                    w_state_next = S_PLAY;
                end
            endcase
        end
    end

    // State, position and frame-tick edge detector registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_PLAY;
            r_x          <= L_X_START;
            r_y          <= L_Y_START;
            r_div        <= 4'd0;
            r_tick_d     <= 1'b0;
            r_frame_tick <= 1'b0;
            r_goal       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_div        <= w_div_next;
            r_tick_d     <= w_tick_cond;
            r_frame_tick <= w_tick_cond & ~r_tick_d;
            r_goal       <= (w_state_next == S_GOAL);
        end
    end

    assign x_ball       = r_x;
    assign y_ball       = r_y;
    assign ball_width   = L_BW5;
    assign goal_reached = r_goal;
    assign frame_tick   = r_frame_tick;
    assign ball_enable  = (hcounter >= r_x) && (hcounter < r_x + L_BW) &&
                          (vcounter >= r_y) && (vcounter < r_y + L_BW);

endmodule
